load_store_sequencer: RTL and testbench

Initiator-side front end for the unified byte-addressed, big-endian, word-wide instruction/data memory. The memory has a combinational word read and a synchronous word write.
Turns CPU load/store requests (byte, halfword, word; signed or unsigned loads) into aligned word accesses. Sub-word stores use read-modify-write.
Sits between the multicycle datapath controller and the memory, and owns memAdr/writeData/memWrite.

---
 rtl/load_store_sequencer_if.sv | 31 +++
 rtl/load_store_sequencer.sv | 161 ++++++++++++++++
 tb/tb_load_store_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_sequencer_if.sv
// CPU request/response and memory word-port signals of the load/store sequencer.
// slave: the sequencer itself; master: the CPU controller plus memory model.
interface load_store_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              signed_ld;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] write_data;
    logic              mem_write;
    logic [DATA_W-1:0] read_data;

    modport slave (
        input  req, we, size, signed_ld, adr, wdata, read_data,
        output ready, done, rdata, err, mem_adr, write_data, mem_write
    );

    modport master (
        output req, we, size, signed_ld, adr, wdata, read_data,
        input  ready, done, rdata, err, mem_adr, write_data, mem_write
    );
endinterface

// File: rtl/load_store_sequencer.sv
// Turns byte/half/word CPU loads and stores into aligned big-endian word accesses;
// sub-word stores are done as read-modify-write.
//
// state   | meaning
// S_IDLE  | ready, waiting for req
// S_READ  | memory word on read_data, captured at the edge
// S_WRITE | mem_write high for this single cycle
// S_DONE  | done pulse, rdata/err valid
module load_store_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    load_store_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              illegal;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;

    assign illegal = (bus.size == 2'b11)
                   || ((bus.size == SZ_HALF) && bus.adr[0])
                   || ((bus.size == SZ_WORD) && (bus.adr[1:0] != 2'b00));

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        byte_sel = 8'h00;
        case (adr_q[1:0])
            2'd0:    byte_sel = bus.read_data[31:24];
            2'd1:    byte_sel = bus.read_data[23:16];
            2'd2:    byte_sel = bus.read_data[15:8];
            default: byte_sel = bus.read_data[7:0];
        endcase
        half_sel = adr_q[1] ? bus.read_data[15:0] : bus.read_data[31:16];
    end

    always_comb begin
        load_val = bus.read_data;
        case (size_q)
            SZ_BYTE: load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_val = bus.read_data;
        endcase
    end

    always_comb begin
        store_word = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                case (adr_q[1:0])
                    2'd0:    store_word = {wdata_q[7:0], word_q[23:0]};
                    2'd1:    store_word = {word_q[31:24], wdata_q[7:0], word_q[15:0]};
                    2'd2:    store_word = {word_q[31:16], wdata_q[7:0], word_q[7:0]};
                    default: store_word = {word_q[31:8], wdata_q[7:0]};
                endcase
            end
            SZ_HALF: store_word = adr_q[1] ? {word_q[31:16], wdata_q[15:0]}
                                           : {wdata_q[15:0], word_q[15:0]};
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    adr_d    = bus.adr;
                    we_d     = bus.we;
                    size_d   = bus.size;
                    signed_d = bus.signed_ld;
                    wdata_d  = bus.wdata;
                    if (illegal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (bus.we && (bus.size == SZ_WORD)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                word_d = bus.read_data;
                if (we_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DONE;
                    rdata_d = load_val;
                    err_d   = 1'b0;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Strobe decoded straight from state so an async reset kills it immediately.
    assign bus.mem_write  = (state_q == S_WRITE);
    assign bus.write_data = bus.mem_write ? store_word : '0;
    assign bus.mem_adr    = {adr_q[ADDR_W-1:2], 2'b00};
    assign bus.ready      = (state_q == S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.rdata      = rdata_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: a word memory model plus a queue of
// expected completions checked when done is seen.
module tb_load_store_sequencer;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr_cyc;
        logic [31:0] wr_data;
        logic [31:0] adr;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exp_t        sb_q[$];
    logic [31:0] last_rdata;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    load_store_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    load_store_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.read_data = mem[bus.mem_adr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write)
            mem[bus.mem_adr[7:2]] <= bus.write_data;
        else if (pl_en)
            mem[pl_idx] <= pl_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err, input int lat,
                           input int wrc, input logic [31:0] wrd);
        exp_t        e;
        int          got;
        int          done_c;
        int          wr_n;
        int          wr_c;
        logic [31:0] wr_v;
        logic [31:0] rd_o;
        logic        err_o;
        logic [31:0] adr_o;
        got = 0; done_c = 0; wr_n = 0; wr_c = 0; wr_v = '0;
        rd_o = '0; err_o = 1'b0; adr_o = '0;
        e = '{tag: tag, rdata: exp_rd, err: exp_err, lat: lat, wr_cyc: wrc,
              wr_data: wrd, adr: {a[31:2], 2'b00}};
        sb_q.push_back(e);
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.signed_ld = sg;
        bus.adr = a; bus.wdata = wd;
        @(posedge clk);
        #1 bus.req = 1'b0;
        for (int c = 1; c <= 8 && got == 0; c++) begin
            @(negedge clk);
            if (bus.mem_write) begin
                wr_n++;
                wr_c = c;
                wr_v = bus.write_data;
            end
            if (bus.done) begin
                got    = 1;
                done_c = c;
                rd_o   = bus.rdata;
                err_o  = bus.err;
                adr_o  = bus.mem_adr;
            end
        end
        if (got == 0) begin
            check({tag, "_timeout"}, 32'(got), 32'd1);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_lat"}, 32'(done_c), 32'(e.lat));
            check({e.tag, "_rdata"}, rd_o, e.rdata);
            check({e.tag, "_err"}, 32'(err_o), 32'(e.err));
            check({e.tag, "_memadr"}, adr_o, e.adr);
            check({e.tag, "_nwrites"}, 32'(wr_n), (e.wr_cyc != 0) ? 32'd1 : 32'd0);
            if (e.wr_cyc != 0) begin
                check({e.tag, "_wrcyc"}, 32'(wr_c), 32'(e.wr_cyc));
                check({e.tag, "_wrdata"}, wr_v, e.wr_data);
            end
            last_rdata = e.rdata;
        end
    endtask

    initial begin
        checks = 0; failures = 0; last_rdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.signed_ld = 1'b0;
        bus.adr = '0; bus.wdata = '0;
        rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_memadr", bus.mem_adr, 32'd0);
        check("rst_wdata", bus.write_data, 32'd0);
        check("rst_memwrite", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        preload(6'd0, 32'h0);
        preload(6'd5, 32'h0);
        preload(6'd4, 32'h11223344);
        run_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 2, 0, 32'h0);

        preload(6'd4, 32'h112233F4);
        run_req("lb13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFF4, 1'b0, 2, 0, 32'h0);
        run_req("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000F4, 1'b0, 2, 0, 32'h0);
        run_req("lbu10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h00000011, 1'b0, 2, 0, 32'h0);

        preload(6'd4, 32'h11223344);
        run_req("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, last_rdata, 1'b0, 3, 2, 32'h11AB3344);
        run_req("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11AB3344, 1'b0, 2, 0, 32'h0);

        preload(6'd4, 32'h11223344);
        run_req("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, last_rdata, 1'b0, 3, 2, 32'h1122BEEF);
        check("mem_after_sh", mem[4], 32'h1122BEEF);
        run_req("lh12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0, 32'h0);
        run_req("lhu12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 32'h0);

        run_req("sw14", 1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, last_rdata, 1'b0, 2, 1, 32'hCAFEF00D);
        run_req("lw14", 1'b0, 2'b10, 1'b1, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 32'h0);

        run_req("ill_lw12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, last_rdata, 1'b1, 1, 0, 32'h0);
        run_req("ill_sh11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, last_rdata, 1'b1, 1, 0, 32'h0);
        run_req("ill_sz11", 1'b1, 2'b11, 1'b0, 32'h10, 32'h5678, last_rdata, 1'b1, 1, 0, 32'h0);
        check("mem_after_illegal", mem[4], 32'h1122BEEF);

        // Reset while the sub-word store is in READ.
        preload(6'd4, 32'h11223344);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.signed_ld = 1'b0;
        bus.adr = 32'h11; bus.wdata = 32'hAB;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstR_memwrite", 32'(bus.mem_write), 32'd0);
        check("rstR_ready", 32'(bus.ready), 32'd1);
        check("rstR_done", 32'(bus.done), 32'd0);
        check("rstR_rdata", bus.rdata, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        last_rdata = '0;
        check("rstR_mem", mem[4], 32'h11223344);
        run_req("rstR_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 2, 0, 32'h0);

        // Reset while the sub-word store is in WRITE, before the write edge.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.signed_ld = 1'b0;
        bus.adr = 32'h11; bus.wdata = 32'hAB;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstW_pre_memwrite", 32'(bus.mem_write), 32'd1);
        check("rstW_pre_wdata", bus.write_data, 32'h11AB3344);
        rst = 1'b1;
        #1;
        check("rstW_memwrite", 32'(bus.mem_write), 32'd0);
        check("rstW_wdata", bus.write_data, 32'd0);
        check("rstW_ready", 32'(bus.ready), 32'd1);
        check("rstW_done", 32'(bus.done), 32'd0);
        check("rstW_rdata", bus.rdata, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        last_rdata = '0;
        check("rstW_mem", mem[4], 32'h11223344);
        run_req("rstW_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 2, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
